// File: rtl/fp32_mul_arb_pkg.sv
// rtl/fp32_mul_arb_pkg.sv - shared constants, tag type and sizing helpers for the fp32 multiplier arbiter
//
// Purpose: default sizes for the shared-multiplier arbiter, the 1-bit
// requester tag carried through the in-order tag FIFO, and width helpers
// that keep the top and the FIFO in agreement for any DEPTH override.
// Ports: none (package).

package fp32_mul_arb_pkg;

    localparam int DEPTH = 4;
    localparam int DW    = 32;

    // Count must represent 0..DEPTH inclusive, hence the extra bit.
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // Identifies which requester a result belongs to.
    typedef logic tag_t;

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fp32_mul_tag_fifo.sv
// rtl/fp32_mul_tag_fifo.sv - in-order tag FIFO recording which requester owns each outstanding multiply
//
// Purpose: holds one tag per multiply issued to the core; the head names the
// requester the next core result is routed to.
// Ports:
//   clk_i    clock, rising edge
//   rst_ni   asynchronous active-low reset (pointers and count cleared)
//   push_i   write tag_i at the tail (ignored when full)
//   tag_i    tag to store
//   pop_i    drop the head entry (ignored when empty)
//   head_o   tag at the head, meaningful when count_o != 0
//   count_o  number of stored tags, 0..DEPTH

module fp32_mul_tag_fifo #(
    parameter int DEPTH = fp32_mul_arb_pkg::DEPTH
) (
    input  logic                                      clk_i,
    input  logic                                      rst_ni,
    input  logic                                      push_i,
    input  fp32_mul_arb_pkg::tag_t                    tag_i,
    input  logic                                      pop_i,
    output fp32_mul_arb_pkg::tag_t                    head_o,
    output logic [fp32_mul_arb_pkg::cnt_width(DEPTH)-1:0] count_o
);
    import fp32_mul_arb_pkg::*;

    localparam int CW = cnt_width(DEPTH);
    localparam int PW = ptr_width(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    tag_t          mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    // Full refuses a push even when a pop happens in the same cycle.
    assign do_push = push_i && (count_q < CW'(DEPTH));
    assign do_pop  = pop_i && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Explicit wrap keeps non-power-of-two depths correct.
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read while count_q is nonzero.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= tag_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fp32_mul_share_arb.sv
// rtl/fp32_mul_share_arb.sv - round-robin sharing of one fp32 multiplier core between two requesters
//
// Purpose: arbitrates two operand streams onto a single multiplier core and
// routes each in-order core result back to the requester that issued it.
// Operand and result paths are purely combinational; only the tag FIFO,
// the round-robin bit and the sticky error flag are registered.
// Ports:
//   nvdla_core_clk / nvdla_core_rstn   clock, asynchronous active-low reset
//   reqN_pvld/prdy/a/b (N=0,1)         requester operand pairs
//   mul_in_pvld/prdy, mul_a/b          operand pair to the shared core
//   mul_out_pvld/prdy, mul_z           result from the shared core
//   rspN_pvld/prdy/z (N=0,1)           results back to the requesters
//   busy                               at least one multiply outstanding
//   err                                sticky: core result with nothing outstanding

module fp32_mul_share_arb #(
    parameter int DEPTH = fp32_mul_arb_pkg::DEPTH,
    parameter int DW    = fp32_mul_arb_pkg::DW
) (
    input  logic          nvdla_core_clk,
    input  logic          nvdla_core_rstn,
    input  logic          req0_pvld,
    output logic          req0_prdy,
    input  logic [DW-1:0] req0_a,
    input  logic [DW-1:0] req0_b,
    input  logic          req1_pvld,
    output logic          req1_prdy,
    input  logic [DW-1:0] req1_a,
    input  logic [DW-1:0] req1_b,
    output logic          mul_in_pvld,
    input  logic          mul_in_prdy,
    output logic [DW-1:0] mul_a,
    output logic [DW-1:0] mul_b,
    input  logic          mul_out_pvld,
    output logic          mul_out_prdy,
    input  logic [DW-1:0] mul_z,
    output logic          rsp0_pvld,
    input  logic          rsp0_prdy,
    output logic [DW-1:0] rsp0_z,
    output logic          rsp1_pvld,
    input  logic          rsp1_prdy,
    output logic [DW-1:0] rsp1_z,
    output logic          busy,
    output logic          err
);
    import fp32_mul_arb_pkg::*;

    localparam int CW = cnt_width(DEPTH);

    logic          rr_q, rr_d;
    logic          err_q, err_d;
    tag_t          grant;
    tag_t          head;
    logic [CW-1:0] count;
    logic          not_full;
    logic          has_tag;
    logic          in_xfer;
    logic          out_xfer;

    assign not_full = count < CW'(DEPTH);
    assign has_tag  = count != '0;

    // rr_q names the preferred requester; fall back to the other one when
    // the preferred side is idle.
    always_comb begin
        grant = 1'b0;
        if (rr_q) begin
            grant = req1_pvld ? 1'b1 : 1'b0;
        end else begin
            grant = req0_pvld ? 1'b0 : 1'b1;
        end
    end

    // Operand side: valid is independent of mul_in_prdy.
    assign mul_in_pvld = (req0_pvld | req1_pvld) & not_full;
    assign req0_prdy   = ~grant & mul_in_prdy & not_full;
    assign req1_prdy   =  grant & mul_in_prdy & not_full;
    assign mul_a       = grant ? req1_a : req0_a;
    assign mul_b       = grant ? req1_b : req0_b;
    assign in_xfer     = mul_in_pvld & mul_in_prdy;

    // Result side: only the head-tag requester sees the core result, and
    // only its ready can release the core.
    assign rsp0_pvld    = has_tag & ~head & mul_out_pvld;
    assign rsp1_pvld    = has_tag &  head & mul_out_pvld;
    assign mul_out_prdy = has_tag & (head ? rsp1_prdy : rsp0_prdy);
    assign rsp0_z       = mul_z;
    assign rsp1_z       = mul_z;
    assign out_xfer     = mul_out_pvld & mul_out_prdy;

    assign busy = has_tag;
    assign err  = err_q;

    always_comb begin
        rr_d  = in_xfer ? ~grant : rr_q;
        err_d = err_q | (~has_tag & mul_out_pvld);
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            rr_q  <= 1'b0;
            err_q <= 1'b0;
        end else begin
            rr_q  <= rr_d;
            err_q <= err_d;
        end
    end

    fp32_mul_tag_fifo #(
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk_i   (nvdla_core_clk),
        .rst_ni  (nvdla_core_rstn),
        .push_i  (in_xfer),
        .tag_i   (grant),
        .pop_i   (out_xfer),
        .head_o  (head),
        .count_o (count)
    );

endmodule

// File: tb/tb_fp32_mul_share_arb.sv
// tb/tb_fp32_mul_share_arb.sv - scoreboard bench for the shared fp32 multiplier arbiter

module tb_fp32_mul_share_arb;

    localparam int DEPTH = 4;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0_pvld, req0_prdy, req1_pvld, req1_prdy;
    logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
    logic          mul_in_pvld, mul_in_prdy;
    logic [DW-1:0] mul_a, mul_b;
    logic          mul_out_pvld, mul_out_prdy;
    logic [DW-1:0] mul_z;
    logic          rsp0_pvld, rsp0_prdy, rsp1_pvld, rsp1_prdy;
    logic [DW-1:0] rsp0_z, rsp1_z;
    logic          busy, err;

    always #5 clk = ~clk;

    fp32_mul_share_arb #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rst_n),
        .req0_pvld       (req0_pvld),
        .req0_prdy       (req0_prdy),
        .req0_a          (req0_a),
        .req0_b          (req0_b),
        .req1_pvld       (req1_pvld),
        .req1_prdy       (req1_prdy),
        .req1_a          (req1_a),
        .req1_b          (req1_b),
        .mul_in_pvld     (mul_in_pvld),
        .mul_in_prdy     (mul_in_prdy),
        .mul_a           (mul_a),
        .mul_b           (mul_b),
        .mul_out_pvld    (mul_out_pvld),
        .mul_out_prdy    (mul_out_prdy),
        .mul_z           (mul_z),
        .rsp0_pvld       (rsp0_pvld),
        .rsp0_prdy       (rsp0_prdy),
        .rsp0_z          (rsp0_z),
        .rsp1_pvld       (rsp1_pvld),
        .rsp1_prdy       (rsp1_prdy),
        .rsp1_z          (rsp1_z),
        .busy            (busy),
        .err             (err)
    );

    typedef struct {
        logic          tag;
        logic [DW-1:0] z;
    } exp_t;

    exp_t sb_q[$];
    int   grant_log[$];
    int   route_log[$];
    int   acc_cnt;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic rr_m, err_m;
    logic core_en, force_out;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
        end
    endtask

    // Stand-in for the external core: any deterministic function of the operands.
    function automatic logic [DW-1:0] core_f(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return a ^ {b[15:0], b[31:16]} ^ 32'h3f80_0000;
    endfunction

    task automatic rand_ops();
        req0_a = $urandom; req0_b = $urandom;
        req1_a = $urandom; req1_b = $urandom;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req0_pvld = 1'b0; req1_pvld = 1'b0;
        mul_in_prdy = 1'b1; rsp0_prdy = 1'b1; rsp1_prdy = 1'b1;
        core_en = 1'b0; force_out = 1'b0; mul_out_pvld = 1'b0; mul_z = '0;
        sb_q.delete(); grant_log.delete(); route_log.delete();
        acc_cnt = 0; rr_m = 1'b0; err_m = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // One clock: drive core outputs from the scoreboard, check at negedge,
    // advance the reference model, return 1 time unit after the posedge.
    task automatic cycle();
        logic g, nf, has, head, exp_in, exp_oprdy, in_x, out_x;
        logic [DW-1:0] hz;
        mul_out_pvld = (core_en && sb_q.size() > 0) || force_out;
        mul_z        = (sb_q.size() > 0) ? sb_q[0].z : 32'hdead_beef;
        @(negedge clk);
        nf = sb_q.size() < DEPTH;
        if (rr_m) g = req1_pvld ? 1'b1 : 1'b0;
        else      g = req0_pvld ? 1'b0 : 1'b1;
        exp_in = (req0_pvld || req1_pvld) && nf;
        check_eq("mul_in_pvld", mul_in_pvld, exp_in);
        check_eq("req0_prdy", req0_prdy, !g && mul_in_prdy && nf);
        check_eq("req1_prdy", req1_prdy, g && mul_in_prdy && nf);
        if (exp_in) begin
            check_eq("mul_a", mul_a, g ? req1_a : req0_a);
            check_eq("mul_b", mul_b, g ? req1_b : req0_b);
        end
        has  = sb_q.size() > 0;
        head = has ? sb_q[0].tag : 1'b0;
        exp_oprdy = has && (head ? rsp1_prdy : rsp0_prdy);
        check_eq("mul_out_prdy", mul_out_prdy, exp_oprdy);
        check_eq("rsp0_pvld", rsp0_pvld, has && !head && mul_out_pvld);
        check_eq("rsp1_pvld", rsp1_pvld, has && head && mul_out_pvld);
        check_eq("busy", busy, has);
        check_eq("err", err, err_m);
        in_x  = exp_in && mul_in_prdy;
        out_x = exp_oprdy && mul_out_pvld;
        if (out_x) begin
            hz = head ? rsp1_z : rsp0_z;
            check_eq("sb_z", hz, sb_q[0].z);
            route_log.push_back(int'(head));
            void'(sb_q.pop_front());
        end
        if (!has && mul_out_pvld) err_m = 1'b1;
        if (in_x) begin
            sb_q.push_back('{tag: g, z: core_f(g ? req1_a : req0_a, g ? req1_b : req0_b)});
            rr_m = !g;
            grant_log.push_back(int'(g));
            acc_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        rst_n = 1'b0;
        req0_pvld = 1'b0; req1_pvld = 1'b0; rand_ops();
        mul_in_prdy = 1'b1; mul_out_pvld = 1'b0; mul_z = '0;
        rsp0_prdy = 1'b1; rsp1_prdy = 1'b1;
        #12;
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_err", err, 1'b0);
        check_eq("rst_rsp0_pvld", rsp0_pvld, 1'b0);
        check_eq("rst_rsp1_pvld", rsp1_pvld, 1'b0);
        check_eq("rst_mul_in_pvld", mul_in_pvld, 1'b0);
        do_reset();

        // Both requesters valid, everything ready: alternate grants and routes
        core_en = 1'b1; req0_pvld = 1'b1; req1_pvld = 1'b1;
        for (int i = 0; i < 8; i++) begin rand_ops(); cycle(); end
        req0_pvld = 1'b0; req1_pvld = 1'b0;
        repeat (4) cycle();
        check_eq("alt_grant_n", grant_log.size() >= 4, 1'b1);
        check_eq("alt_route_n", route_log.size() >= 4, 1'b1);
        for (int i = 0; i < 4 && i < grant_log.size() && i < route_log.size(); i++) begin
            check_eq("alt_grant", grant_log[i], i % 2);
            check_eq("alt_route", route_log[i], i % 2);
        end

        // Only requester 1 valid: granted every cycle
        do_reset();
        core_en = 1'b1; req1_pvld = 1'b1;
        for (int i = 0; i < 5; i++) begin rand_ops(); cycle(); end
        req1_pvld = 1'b0;
        repeat (3) cycle();
        check_eq("r1_only_cnt", acc_cnt, 5);
        foreach (grant_log[i]) check_eq("r1_only_grant", grant_log[i], 1);

        // Fill to DEPTH with the core stalled; no bypass on the pop cycle
        do_reset();
        req0_pvld = 1'b1;
        for (int i = 0; i < 5; i++) begin rand_ops(); cycle(); end
        check_eq("full_acc", acc_cnt, 4);
        check_eq("full_busy", busy, 1'b1);
        core_en = 1'b1;
        cycle();
        check_eq("no_bypass", acc_cnt, 4);
        cycle();
        check_eq("acc_after_pop", acc_cnt, 5);
        req0_pvld = 1'b0;
        repeat (6) cycle();
        check_eq("drained", busy, 1'b0);

        // Head tag 0 with rsp0 stalled: nothing leaks to rsp1
        do_reset();
        req0_pvld = 1'b1; rand_ops(); cycle();
        req0_pvld = 1'b0; core_en = 1'b1; rsp0_prdy = 1'b0; rsp1_prdy = 1'b1;
        repeat (3) cycle();
        check_eq("held_cnt", sb_q.size(), 1);
        rsp0_prdy = 1'b1;
        repeat (2) cycle();
        check_eq("held_release", sb_q.size(), 0);

        // Core result with nothing outstanding: sticky err
        do_reset();
        force_out = 1'b1; cycle();
        force_out = 1'b0; cycle();
        check_eq("err_set", err, 1'b1);
        repeat (3) cycle();
        check_eq("err_sticky", err, 1'b1);

        // Asynchronous reset mid-stream with three outstanding and err set
        req0_pvld = 1'b1;
        for (int i = 0; i < 3; i++) begin rand_ops(); cycle(); end
        req0_pvld = 1'b0;
        check_eq("pre_rst_busy", busy, 1'b1);
        mul_out_pvld = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_busy", busy, 1'b0);
        check_eq("arst_err", err, 1'b0);
        check_eq("arst_rsp0_pvld", rsp0_pvld, 1'b0);
        check_eq("arst_rsp1_pvld", rsp1_pvld, 1'b0);
        do_reset();
        req0_pvld = 1'b1; req1_pvld = 1'b1; rand_ops();
        cycle();
        check_eq("arst_rr_grant_n", grant_log.size(), 1);
        if (grant_log.size() > 0) check_eq("arst_rr_grant", grant_log[0], 0);
        req0_pvld = 1'b0; req1_pvld = 1'b0;
        repeat (2) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
